// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO, configurable frame format
// (data bits, parity, stop bits) and optional CTS flow control.
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 25_500_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int USE_CTS    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [DATA_BITS-1:0]        wr_data,
   input  logic                        cts_n,
   output logic                        txd,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int BIT_PERIOD = CLOCK_FREQ / BAUD;
   localparam int STOP_LEN   = BIT_PERIOD * STOP_BITS;
   localparam int CNT_W      = $clog2(STOP_LEN);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int IDX_W      = $clog2(DATA_BITS);
   localparam int OCC_W      = PTR_W + 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Even parity is the plain XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      logic p;
      p = ^d;
      if (PARITY == 1) begin
         parity_bit = ~p;
      end else begin
         parity_bit = p;
      end
   endfunction

   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic [IDX_W-1:0]       idx_r, idx_s;
   logic [DATA_BITS-1:0]   shift_r, shift_s;
   logic                   txd_r, txd_s;
   logic                   busy_r, wr_ready_r;
   logic [OCC_W-1:0]       count_r, count_s;
   logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
   logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
   logic                   cts_meta_r, cts_sync_r;
   logic                   cts_ok_s, push_s, pop_s, empty_s;

   assign cts_ok_s   = (USE_CTS != 0) ? ~cts_sync_r : 1'b1;
   assign empty_s    = (count_r == OCC_ZERO);
   assign push_s     = wr_valid & wr_ready_r;
   assign txd        = txd_r;
   assign busy       = busy_r;
   assign wr_ready   = wr_ready_r;
   assign fifo_count = count_r;

   // Frame sequencer: next state, baud counter, bit index and FIFO pop.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + 1'b1;
      idx_s   = idx_r;
      shift_s = shift_r;
      pop_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            cnt_s = CNT_ZERO;
            if (!empty_s && cts_ok_s) begin
               pop_s   = 1'b1;
               shift_s = mem_r[rd_ptr_r];
               state_s = S_START;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s   = CNT_ZERO;
               idx_s   = IDX_ZERO;
               state_s = S_DATA;
            end else begin
               state_s = S_START;
            end
         end
         S_DATA: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s = CNT_ZERO;
               if (idx_r == IDX_LAST) begin
                  idx_s   = IDX_ZERO;
                  state_s = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_s = idx_r + 1'b1;
               end
            end else begin
               state_s = S_DATA;
            end
         end
         S_PARITY: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s   = CNT_ZERO;
               state_s = S_STOP;
            end else begin
               state_s = S_PARITY;
            end
         end
         S_STOP: begin
            if (cnt_r == STOP_LAST) begin
               cnt_s = CNT_ZERO;
               // Chaining straight into the next start bit keeps frames back-to-back.
               if (!empty_s && cts_ok_s) begin
                  pop_s   = 1'b1;
                  shift_s = mem_r[rd_ptr_r];
                  state_s = S_START;
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               state_s = S_STOP;
            end
         end
         default: begin
            cnt_s   = CNT_ZERO;
            state_s = S_IDLE;
         end
      endcase
   end

   // Line level for the state being entered, so txd can be registered.
   always_comb begin
      case (state_s)
         S_IDLE:   txd_s = 1'b1;
         S_START:  txd_s = 1'b0;
         S_DATA:   txd_s = shift_s[idx_s];
         S_PARITY: txd_s = parity_bit(shift_s);
         S_STOP:   txd_s = 1'b1;
         default:  txd_s = 1'b1;
      endcase
   end

   // Occupancy update; simultaneous push and pop cancel.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + 1'b1;
         2'b01:   count_s = count_r - 1'b1;
         default: count_s = count_r;
      endcase
   end

   // Sequencer, FIFO pointers, status outputs and CTS synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         cnt_r      <= CNT_ZERO;
         idx_r      <= IDX_ZERO;
         shift_r    <= {DATA_BITS{1'b0}};
         txd_r      <= 1'b1;
         busy_r     <= 1'b0;
         wr_ready_r <= 1'b1;
         count_r    <= OCC_ZERO;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         cts_meta_r <= 1'b1;
         cts_sync_r <= 1'b1;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         idx_r      <= idx_s;
         shift_r    <= shift_s;
         txd_r      <= txd_s;
         busy_r     <= (state_s != S_IDLE) || (count_s != OCC_ZERO);
         wr_ready_r <= (count_s != OCC_FULL);
         count_r    <= count_s;
         wr_ptr_r   <= push_s ? wr_ptr_r + 1'b1 : wr_ptr_r;
         rd_ptr_r   <= pop_s ? rd_ptr_r + 1'b1 : rd_ptr_r;
         cts_meta_r <= cts_n;
         cts_sync_r <= cts_meta_r;
      end
   end

   // FIFO storage; stale entries are unreachable once count is cleared.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four instances cover 8N1/CTS/depth-4,
// even parity with two stops, odd parity, and five data bits.
module tb_uart_tx_fifo;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       cts_n;
   logic [3:0] wv;
   logic [7:0] wd [4];
   wire  [3:0] wr_rdy, txd_w, bz;
   wire  [2:0] fc0;
   wire  [4:0] fc1, fc2, fc3;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] q0[$], q1[$], q2[$], q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4), .USE_CTS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wv[0]), .wr_ready(wr_rdy[0]), .wr_data(wd[0]),
      .cts_n(cts_n), .txd(txd_w[0]), .busy(bz[0]), .fifo_count(fc0));
   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(16), .USE_CTS(0)) u1 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wv[1]), .wr_ready(wr_rdy[1]), .wr_data(wd[1]),
      .cts_n(cts_n), .txd(txd_w[1]), .busy(bz[1]), .fifo_count(fc1));
   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(16), .USE_CTS(0)) u2 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wv[2]), .wr_ready(wr_rdy[2]), .wr_data(wd[2]),
      .cts_n(cts_n), .txd(txd_w[2]), .busy(bz[2]), .fifo_count(fc2));
   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16), .USE_CTS(0)) u3 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wv[3]), .wr_ready(wr_rdy[3]), .wr_data(wd[3][4:0]),
      .cts_n(cts_n), .txd(txd_w[3]), .busy(bz[3]), .fifo_count(fc3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string msg);
      n_tests++;
      n_fail++;
      $display("%s", msg);
   endtask

   function automatic void exp_push(input int idx, input logic [7:0] w);
      case (idx)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endfunction

   function automatic logic [7:0] exp_pop(input int idx);
      case (idx)
         0: exp_pop = q0.pop_front();
         1: exp_pop = q1.pop_front();
         2: exp_pop = q2.pop_front();
         default: exp_pop = q3.pop_front();
      endcase
   endfunction

   function automatic int exp_size(input int idx);
      case (idx)
         0: exp_size = q0.size();
         1: exp_size = q1.size();
         2: exp_size = q2.size();
         default: exp_size = q3.size();
      endcase
   endfunction

   // Reference line level of frame bit k: start, data LSB first, parity, stops.
   function automatic logic fbit(input logic [7:0] w, input int k, input int db, input int par);
      logic p;
      p = 1'b0;
      for (int i = 0; i < db; i++) p = p ^ w[i];
      if (k == 0) return 1'b0;
      else if (k <= db) return w[k-1];
      else if (par != 0 && k == db + 1) return (par == 1) ? ~p : p;
      else return 1'b1;
   endfunction

   // Monitor: on each start bit pop the expected word and check every cycle of the frame.
   task automatic mon(input int idx, input int db, input int par, input int sb);
      logic [7:0] w;
      logic       eb, seen;
      int         nbits, nb;
      bit         ab, bad;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && txd_w[idx] === 1'b0) begin
            if (exp_size(idx) == 0) begin
               note_fail($sformatf("FAIL inst%0d unexpected frame: start bit at cycle %0d, no word expected", idx, cyc));
               nb = 0;
               while (bz[idx] !== 1'b0 && nb < 2000) begin
                  @(negedge clk);
                  nb++;
               end
            end else begin
               w     = exp_pop(idx);
               ab    = 1'b0;
               nbits = 1 + db + ((par != 0) ? 1 : 0) + sb;
               for (int k = 0; k < nbits && !ab; k++) begin
                  eb   = fbit(w, k, db, par);
                  bad  = 1'b0;
                  seen = 1'b0;
                  for (int c = 0; c < 10 && !ab; c++) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (rst_n !== 1'b1) ab = 1'b1;
                     else if (!bad) begin
                        seen = txd_w[idx];
                        if (seen !== eb) bad = 1'b1;
                     end
                  end
                  if (!ab) check($sformatf("inst%0d word %02h frame bit %0d", idx, w, k), {31'b0, seen}, {31'b0, eb});
               end
            end
         end
      end
   endtask

   initial mon(0, 8, 0, 1);
   initial mon(1, 8, 2, 2);
   initial mon(2, 8, 1, 1);
   initial mon(3, 5, 0, 1);

   task automatic wr(input int idx, input logic [7:0] w);
      @(negedge clk);
      wv[idx] = 1'b1;
      wd[idx] = w;
      exp_push(idx, w);
      @(negedge clk);
      wv[idx] = 1'b0;
   endtask

   task automatic wait_low(input int idx, output int n, output int t);
      n = 0;
      while (txd_w[idx] !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) note_fail($sformatf("FAIL inst%0d start bit wait: none within %0d cycles", idx, n));
      t = cyc;
   endtask

   task automatic wait_idle(input int idx, output int t);
      int n;
      n = 0;
      while (bz[idx] !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) note_fail($sformatf("FAIL inst%0d idle wait: busy still high after %0d cycles", idx, n));
      t = cyc;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t0, t1;
      int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
      int exp_rdy [6] = '{1, 1, 1, 1, 0, 0};
      rst_n = 1'b0;
      cts_n = 1'b0;
      wv    = 4'b0000;
      for (int i = 0; i < 4; i++) wd[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset txd", {31'b0, txd_w[0]}, 32'd1);
      check("reset busy", {31'b0, bz[0]}, 32'd0);
      check("reset wr_ready", {31'b0, wr_rdy[0]}, 32'd1);
      check("reset fifo_count", {29'b0, fc0}, 32'd0);
      check("reset inst1 fifo_count", {27'b0, fc1}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 8N1 0x55: one-cycle pop latency, 100-cycle frame
      wr(0, 8'h55);
      wait_low(0, n, t0);
      check("8N1 start latency", n, 32'd1);
      wait_idle(0, t1);
      check("8N1 frame length", t1 - t0, 32'd100);

      // Even parity + 2 stops (120 cycles) and odd parity (110 cycles)
      wr(1, 8'h07);
      wait_low(1, n, t0);
      wait_idle(1, t1);
      check("even/2stop frame length", t1 - t0, 32'd120);
      wr(2, 8'h07);
      wait_low(2, n, t0);
      wait_idle(2, t1);
      check("odd frame length", t1 - t0, 32'd110);
      wr(1, 8'h03);
      wr(2, 8'h03);
      wait_idle(1, t1);
      wait_idle(2, t1);

      // Depth-4 FIFO filled during the first frame; sixth write rejected
      @(negedge clk);
      wv[0] = 1'b1;
      t0 = 0;
      for (int k = 0; k < 6; k++) begin
         wd[0] = 8'(8'hA0 + k);
         if (k < 5) exp_push(0, wd[0]);
         @(negedge clk);
         check($sformatf("fill fifo_count after write %0d", k), {29'b0, fc0}, exp_cnt[k]);
         check($sformatf("fill wr_ready after write %0d", k), {31'b0, wr_rdy[0]}, exp_rdy[k]);
         if (k == 1) begin
            check("fill first start bit", {31'b0, txd_w[0]}, 32'd0);
            t0 = cyc;
         end
      end
      wv[0] = 1'b0;
      wait_idle(0, t1);
      check("five back-to-back frames length", t1 - t0, 32'd500);

      // CTS hold, release, and mid-frame deassertion
      cts_n = 1'b1;
      repeat (3) @(negedge clk);
      wr(0, 8'h3C);
      repeat (20) @(negedge clk);
      check("cts hold txd", {31'b0, txd_w[0]}, 32'd1);
      check("cts hold busy", {31'b0, bz[0]}, 32'd1);
      check("cts hold fifo_count", {29'b0, fc0}, 32'd1);
      cts_n = 1'b0;
      n = 0;
      while (txd_w[0] !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n < 3 || n > 4) note_fail($sformatf("FAIL cts release delay: got %0d cycles, expected 3..4", n));
      else n_tests++;
      t0 = cyc;
      wr(0, 8'h81);
      repeat (30) @(negedge clk);
      cts_n = 1'b1;
      while (cyc < t0 + 200) @(negedge clk);
      check("cts held word txd", {31'b0, txd_w[0]}, 32'd1);
      check("cts held word fifo_count", {29'b0, fc0}, 32'd1);
      check("cts held word busy", {31'b0, bz[0]}, 32'd1);
      cts_n = 1'b0;
      wait_low(0, n, t0);
      wait_idle(0, t1);
      check("cts released frame length", t1 - t0, 32'd100);

      // Reset in the middle of a frame with two words queued
      wr(0, 8'h11);
      wr(0, 8'h22);
      wr(0, 8'h33);
      repeat (30) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid-frame reset txd", {31'b0, txd_w[0]}, 32'd1);
      check("mid-frame reset fifo_count", {29'b0, fc0}, 32'd0);
      check("mid-frame reset busy", {31'b0, bz[0]}, 32'd0);
      check("mid-frame reset wr_ready", {31'b0, wr_rdy[0]}, 32'd1);
      q0.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("post-reset txd idle", {31'b0, txd_w[0]}, 32'd1);
      check("post-reset busy", {31'b0, bz[0]}, 32'd0);

      // Five data bits: 70-cycle frames
      wr(3, 8'h1F);
      wait_low(3, n, t0);
      check("5-bit start latency", n, 32'd1);
      wait_idle(3, t1);
      check("5-bit frame length", t1 - t0, 32'd70);
      wr(3, 8'h0A);
      wait_idle(3, t1);

      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("inst%0d frames outstanding", i), exp_size(i), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format (data bits, parity, stop bits) and optional CTS flow control. It accepts words over a valid/ready write port, buffers them, and serialises them LSB-first on txd. When the FIFO holds data, consecutive frames go out back-to-back with no idle gap. It replaces the fixed 8N1 single-byte transmitter on the host serial link.

Parameters:
CLOCK_FREQ, 25_500_000, clk frequency in Hz
BAUD, 115200, line rate; BIT_PERIOD = CLOCK_FREQ / BAUD (integer truncation), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of two, >= 2
USE_CTS, 1, 1 = honour cts_n; 0 = ignore cts_n (always clear to send)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write request
wr_ready  output  1  FIFO can accept a word (= not full)
wr_data  input  DATA_BITS  word to transmit
cts_n  input  1  active-low clear-to-send, asynchronous to clk
txd  output  1  serial output, idle high
busy  output  1  high while a frame is in progress or the FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-low on rst_n; the clock is clk. On reset: txd=1, busy=0, wr_ready=1, fifo_count=0, state=IDLE, baud counter=0, bit index=0, CTS synchroniser flops=1 (not clear). Reset mid-frame truncates the frame: txd returns high immediately and FIFO contents are discarded.
- Write handshake: a word is accepted on a rising edge where wr_valid && wr_ready. wr_ready = (fifo_count != FIFO_DEPTH). A write while full is ignored and the FIFO is left unchanged. A simultaneous push and pop leaves fifo_count unchanged.
- cts_n passes through a 2-flop synchroniser. cts_ok = USE_CTS ? !cts_sync : 1.
- State machine: IDLE, START, DATA, PARITY, STOP. txd is registered and reflects the current state's bit.
  - IDLE: txd=1. On an edge where FIFO is non-empty && cts_ok: pop the head into the shift register, clear the baud counter, go to START.
  - START: txd=0 for BIT_PERIOD cycles, then go to DATA.
  - DATA: txd=shift[bit_idx], bit_idx 0..DATA_BITS-1, BIT_PERIOD cycles per bit. After the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: txd = XOR of data bits (even), or its inverse (odd). BIT_PERIOD cycles, then STOP.
  - STOP: txd=1 for STOP_BITS*BIT_PERIOD cycles. At the end, if FIFO is non-empty && cts_ok, pop and go directly to START (no idle cycle). Otherwise go to IDLE.
- Latency: a word written on edge E into an empty FIFO while IDLE and cts_ok is popped on edge E+1. txd first reads 0 in the cycle after E+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BIT_PERIOD cycles exactly.
- CTS is sampled only at frame start (IDLE or end of STOP). Deassertion mid-frame never truncates the current frame.
- busy = (state != IDLE) || (fifo_count != 0).
- Pointers wrap modulo FIFO_DEPTH. fifo_count holds values 0..FIFO_DEPTH inclusive.
- Baud counter width is $clog2(BIT_PERIOD*STOP_BITS) bits, with no overflow for any legal parameter set.

Test Plan:
1. CLOCK_FREQ=1_000_000, BAUD=100_000 (BIT_PERIOD=10), 8N1, cts_n=0: write 0x55 -> txd reads 0,1,0,1,0,1,0,1,0,1 (start, then LSB first), then stop; each bit 10 cycles, 100 cycles total; busy falls after the stop bit.
2. PARITY=2, 8 bits: write 0x07 -> parity bit 1. With PARITY=1, same word -> parity bit 0. STOP_BITS=2 -> stop high for 20 cycles.
3. FIFO_DEPTH=4: hold wr_valid for 6 cycles with 0xA0..0xA5 while the first frame is starting -> wr_ready drops when fifo_count=4, the 0xA5 write is ignored, and 5 accepted words go out in order with no idle cycle between frames.
4. cts_n=1, write 0x3C -> txd stays high, busy=1, fifo_count=1. Drive cts_n=0 -> start bit begins 3-4 cycles later. Raise cts_n mid-data -> the frame completes and the next queued word is held.
5. Assert rst_n=0 during DATA of a frame with 2 words queued -> txd=1 immediately, fifo_count=0, busy=0. After release, no residual frame is sent.
6. DATA_BITS=5, PARITY=0: write 0x1F -> 7-bit frame of 70 cycles. Verify upper wr_data bits are not transmitted.
